// File: rtl/tensor_core_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tensor_core_instruction_sequencer
//
// Buffers 16-bit host instructions in a FIFO and issues them, one per clock,
// to the tensor core controller. It enforces the controller's timing rules:
//   - A burst header is issued only when all of its payload words are already
//     in the FIFO behind it. The payload then streams out with no gaps.
//   - A burst read (select 00) or read-and-write (select 10) header is held
//     back until OP_LATENCY cycles have passed since the last OPERATE.
//   - Unsupported headers (burst select 11, opcode 11) are dropped, and
//     error_out pulses for one cycle.
//
// Instruction word: bits [1:0] opcode, bits [3:2] select.
//   opcode 00 NOP, 01 OPERATE, 10 BURST, 11 illegal.
//
// Handshake: a host word transfers on a rising clock edge when instr_valid_in
// and instr_ready_out are both high. instr_ready_out comes only from
// registered state, so it does not depend on instr_valid_in in the same cycle.
//
// Ports:
//   clock_in               system clock, rising edge
//   reset_in               asynchronous, active-high reset
//   instr_in[15:0]         host instruction word
//   instr_valid_in         instr_in is valid
//   instr_ready_out        FIFO can accept a word (count < FIFO_DEPTH)
//   issue_instruction_out  registered word to the controller (NOP when idle)
//   busy_out               FIFO not empty, or FSM not in IDLE
//   fifo_count_out         FIFO occupancy
//   error_out              one-cycle pulse when an illegal header is dropped
//   state_out[1:0]         FSM state (0 IDLE, 1 ISSUE, 2 BURST_DATA, 3 OP_WAIT)
//
// Optional feature, macro SEQ_PERF_COUNTERS_EN:
//   perf_clear_in          synchronous clear of both counters
//   perf_issued_out[31:0]  count of non-NOP words issued (saturating)
//   perf_stall_out[31:0]   cycles a non-empty FIFO head was held back
//                          (saturating)
// -----------------------------------------------------------------------------
module tensor_core_instruction_sequencer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int OP_LATENCY  = 2,
    parameter int BURST_BEATS = 5
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic [15:0]                   instr_in,
    input  logic                          instr_valid_in,
    output logic                          instr_ready_out,
    output logic [15:0]                   issue_instruction_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          error_out,
    output logic [1:0]                    state_out
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    input  logic                          perf_clear_in,
    output logic [31:0]                   perf_issued_out,
    output logic [31:0]                   perf_stall_out
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // The +2 keeps each width at least 1 bit, even for a zero parameter.
    localparam int BEAT_W = $clog2(BURST_BEATS + 2);
    localparam int WAIT_W = $clog2(OP_LATENCY + 2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_BURST   = 2'd2;
    localparam logic [1:0] ST_OP_WAIT = 2'd3;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_OPERATE = 2'b01;
    localparam logic [1:0] OP_BURST   = 2'b10;

    localparam logic [CNT_W-1:0]  DEPTH_V    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_NEED = CNT_W'(BURST_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEATS_V    = BEAT_W'(BURST_BEATS);
    localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] OP_LAT_V   = WAIT_W'(OP_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    // ---------------------------------------------------------------- FIFO
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_of_reset;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [15:0]      head;
    logic [1:0]       head_op;
    logic [1:0]       head_sel;

    assign instr_ready_out = out_of_reset && (count < DEPTH_V);
    assign push            = instr_valid_in && instr_ready_out;
    assign fifo_empty      = (count == '0);
    assign head            = mem[rd_ptr];
    assign head_op         = head[1:0];
    assign head_sel        = head[3:2];

    // Storage has no reset; the pointers and count define which entries hold data.
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    // ---------------------------------------------------------------- FSM
    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_n;
    logic              issue_vld;
    logic              drop_err;
    logic              read_like;
    logic [15:0]       issue_q;
    logic              error_q;

    // Burst read and read-and-write depend on the previous OPERATE result.
    assign read_like = (head_sel == 2'b00) || (head_sel == 2'b10);

    always_comb begin
        pop       = 1'b0;
        issue_vld = 1'b0;
        drop_err  = 1'b0;
        state_n   = state;
        beat_n    = beat_cnt;
        // The OPERATE spacing counter always counts down. A burst write
        // issued from OP_WAIT leaves the state, but the counter keeps the
        // spacing for any read-type header that follows.
        wait_n    = (wait_cnt != '0) ? (wait_cnt - WAIT_ONE) : wait_cnt;

        if (state == ST_BURST) begin
            // All payload words were in the FIFO when the header issued.
            pop       = 1'b1;
            issue_vld = 1'b1;
            beat_n    = beat_cnt - BEAT_ONE;
            if (beat_cnt == BEAT_ONE) begin
                state_n = ST_ISSUE;
            end
        end else if (fifo_empty) begin
            if (state == ST_ISSUE) begin
                state_n = ST_IDLE;
            end
        end else begin
            case (head_op)
                OP_NOP: begin
                    pop       = 1'b1;
                    issue_vld = 1'b1;
                    if (state == ST_IDLE) begin
                        state_n = ST_ISSUE;
                    end
                end
                OP_OPERATE: begin
                    pop       = 1'b1;
                    issue_vld = 1'b1;
                    wait_n    = OP_LAT_V;
                    state_n   = ST_OP_WAIT;
                end
                OP_BURST: begin
                    if (head_sel == 2'b11) begin
                        pop      = 1'b1;
                        drop_err = 1'b1;
                    end else if ((count >= BURST_NEED) &&
                                 !(read_like && (wait_cnt != '0))) begin
                        pop       = 1'b1;
                        issue_vld = 1'b1;
                        beat_n    = BEATS_V;
                        state_n   = ST_BURST;
                    end
                end
                default: begin
                    pop      = 1'b1;
                    drop_err = 1'b1;
                end
            endcase
        end

        // OP_WAIT ends when the spacing counter reaches zero.
        if ((state_n == ST_OP_WAIT) && (wait_n == '0)) begin
            state_n = ST_ISSUE;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            issue_q      <= 16'h0000;
            error_q      <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            state        <= state_n;
            beat_cnt     <= beat_n;
            wait_cnt     <= wait_n;
            issue_q      <= issue_vld ? head : 16'h0000;
            error_q      <= drop_err;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign issue_instruction_out = issue_q;
    assign error_out             = error_q;
    assign fifo_count_out        = count;
    assign busy_out              = !fifo_empty || (state != ST_IDLE);
    assign state_out             = state;

`ifdef SEQ_PERF_COUNTERS_EN
    // ------------------------------------------------ performance counters
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
    logic        count_issue;
    logic        count_stall;

    // Payload words are counted even when their low bits look like NOP.
    assign count_issue = issue_vld && !((state != ST_BURST) && (head_op == OP_NOP));
    assign count_stall = !fifo_empty && !pop;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (perf_clear_in) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (count_issue && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (count_stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued_out = perf_issued;
    assign perf_stall_out  = perf_stall;
`endif

endmodule

// File: tb/tb_tensor_core_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tensor_core_instruction_sequencer (default build).
// Directed instruction streams are compared cycle by cycle with hand-written
// traces of {error_out, issue_instruction_out}. A fill test checks FIFO-full
// behaviour, and a scoreboard checks that every issued word comes out in
// push order.
// -----------------------------------------------------------------------------
module tb_tensor_core_instruction_sequencer;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic [15:0] instr_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [15:0] issue_instruction_out;
    logic        busy_out;
    logic [4:0]  fifo_count_out;
    logic        error_out;
    logic [1:0]  state_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] stim_q[$];
    logic [16:0] exp_trace[$];
    logic        busy_log[$];
    logic [15:0] exp_q[$];

    tensor_core_instruction_sequencer dut (
        .clock_in              (clock_in),
        .reset_in              (reset_in),
        .instr_in              (instr_in),
        .instr_valid_in        (instr_valid_in),
        .instr_ready_out       (instr_ready_out),
        .issue_instruction_out (issue_instruction_out),
        .busy_out              (busy_out),
        .fifo_count_out        (fifo_count_out),
        .error_out             (error_out),
        .state_out             (state_out)
    );

    // ------------------------------------------------------- clock / reset
    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ------------------------------------------------------------ checking
    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    // -------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic clear_vectors();
        stim_q.delete();
        exp_trace.delete();
        busy_log.delete();
    endtask

    task automatic exp_word(input logic [15:0] w);
        exp_trace.push_back({1'b0, w});
    endtask

    task automatic exp_nops(input int n);
        for (int i = 0; i < n; i++) exp_trace.push_back(17'h00000);
    endtask

    task automatic exp_error();
        exp_trace.push_back(17'h10000);
    endtask

    // Pushes stim_q back to back (honouring ready) and compares each cycle
    // with exp_trace. Each entry is the value seen just after that edge.
    task automatic run_trace(input string tag);
        int   idx;
        logic rdy;
        idx = 0;
        for (int cyc = 0; cyc < exp_trace.size(); cyc++) begin
            if (idx < stim_q.size()) begin
                instr_in       = stim_q[idx];
                instr_valid_in = 1'b1;
            end else begin
                instr_in       = 16'h0000;
                instr_valid_in = 1'b0;
            end
            rdy = instr_ready_out;
            tick();
            if (instr_valid_in && rdy) idx++;
            check_eq($sformatf("%s[%0d]", tag, cyc),
                     {15'd0, error_out, issue_instruction_out},
                     {15'd0, exp_trace[cyc]});
            busy_log.push_back(busy_out);
        end
        instr_valid_in = 1'b0;
        instr_in       = 16'h0000;
        check_eq({tag, "_consumed"}, idx, stim_q.size());
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int   idx;
        int   full_seen;
        int   max_cnt;
        bit   after_full;
        bit   first_full_done;
        logic rdy;
        logic acc;
        logic [4:0] cnt_pre;

        reset_in       = 1'b1;
        instr_in       = 16'h0000;
        instr_valid_in = 1'b0;
        #2;
        check_eq("rst_issue", issue_instruction_out, 16'h0000);
        check_eq("rst_count", fifo_count_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_error", error_out, 0);
        check_eq("rst_ready", instr_ready_out, 0);
        check_eq("rst_state", state_out, 0);
        tick();
        check_eq("rst_ready_held", instr_ready_out, 0);
        reset_in = 1'b0;
        tick();
        check_eq("ready_after_release", instr_ready_out, 1);

        // Burst write: header waits for its 5 payload words, then streams.
        clear_vectors();
        stim_q = '{16'h0006, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
        exp_nops(6);
        exp_word(16'h0006); exp_word(16'h0102); exp_word(16'h0304);
        exp_word(16'h0506); exp_word(16'h0708); exp_word(16'h090A);
        exp_nops(1);
        run_trace("burst_wr");
        check_eq("burst_wr_busy_last", busy_log[11], 1);
        check_eq("burst_wr_busy_fall", busy_log[12], 0);
        check_eq("burst_wr_count", fifo_count_out, 0);

        // Partial burst: header plus 3 payload words stalls.
        clear_vectors();
        stim_q = '{16'h0002, 16'h1111, 16'h2222, 16'h3333};
        exp_nops(7);
        run_trace("partial_hold");
        check_eq("partial_count", fifo_count_out, 4);
        check_eq("partial_state", state_out, 0);
        check_eq("partial_ready", instr_ready_out, 1);
        clear_vectors();
        stim_q = '{16'h4444, 16'h5555};
        exp_nops(2);
        exp_word(16'h0002); exp_word(16'h1111); exp_word(16'h2222);
        exp_word(16'h3333); exp_word(16'h4444); exp_word(16'h5555);
        exp_nops(1);
        run_trace("partial_go");

        // Operate then burst read. The first burst keeps everything queued,
        // so the read is held only by the operate spacing (2 NOPs).
        clear_vectors();
        stim_q = '{16'h0006, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005,
                   16'h0005, 16'h0002, 16'hB001, 16'hB002, 16'hB003, 16'hB004,
                   16'hB005};
        exp_nops(6);
        exp_word(16'h0006);
        exp_word(16'hA001); exp_word(16'hA002); exp_word(16'hA003);
        exp_word(16'hA004); exp_word(16'hA005);
        exp_word(16'h0005);
        exp_nops(2);
        exp_word(16'h0002);
        exp_word(16'hB001); exp_word(16'hB002); exp_word(16'hB003);
        exp_word(16'hB004); exp_word(16'hB005);
        exp_nops(1);
        run_trace("op_read");

        // Operate then burst write: no spacing is required.
        clear_vectors();
        stim_q = '{16'h0006, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005,
                   16'h0005, 16'h0006, 16'hC001, 16'hC002, 16'hC003, 16'hC004,
                   16'hC005};
        exp_nops(6);
        exp_word(16'h0006);
        exp_word(16'hA001); exp_word(16'hA002); exp_word(16'hA003);
        exp_word(16'hA004); exp_word(16'hA005);
        exp_word(16'h0005);
        exp_word(16'h0006);
        exp_word(16'hC001); exp_word(16'hC002); exp_word(16'hC003);
        exp_word(16'hC004); exp_word(16'hC005);
        exp_nops(1);
        run_trace("op_write");

        // Illegal headers: burst select 11, then opcode 11, then a real NOP.
        clear_vectors();
        stim_q = '{16'h000E, 16'h0003, 16'h0000};
        exp_nops(1);
        exp_error();
        exp_error();
        exp_nops(2);
        run_trace("illegal");
        check_eq("illegal_state", state_out, 0);
        check_eq("illegal_count", fifo_count_out, 0);

        // Fill: repeated operate + burst read groups build up the FIFO
        // during the spacing stalls until it reaches 16 entries.
        clear_vectors();
        exp_q.delete();
        for (int g = 0; g < 8; g++) begin
            stim_q.push_back(16'h0005);
            stim_q.push_back(16'h0002);
            for (int b = 0; b < 5; b++) stim_q.push_back(16'($urandom_range(1, 16'hFFFF)));
        end
        idx             = 0;
        full_seen       = 0;
        max_cnt         = 0;
        after_full      = 1'b0;
        first_full_done = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (idx == stim_q.size() && exp_q.size() == 0 && !busy_out) break;
            if (idx < stim_q.size()) begin
                instr_in       = stim_q[idx];
                instr_valid_in = 1'b1;
            end else begin
                instr_in       = 16'h0000;
                instr_valid_in = 1'b0;
            end
            rdy     = instr_ready_out;
            cnt_pre = fifo_count_out;
            if (cnt_pre == 5'd16) begin
                full_seen++;
                check_eq("full_ready", rdy, 0);
            end
            tick();
            acc = instr_valid_in && rdy;
            if (acc) begin
                exp_q.push_back(instr_in);
                idx++;
            end
            if (after_full) begin
                check_eq("full_accept_after_pop", acc, 1);
                after_full = 1'b0;
            end
            if (cnt_pre == 5'd16 && !first_full_done) begin
                check_eq("full_first_pop", fifo_count_out, 15);
                first_full_done = 1'b1;
                after_full      = 1'b1;
            end
            if (int'(fifo_count_out) > max_cnt) max_cnt = int'(fifo_count_out);
            if (issue_instruction_out != 16'h0000) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", issue_instruction_out, 0);
                else check_eq("sb_order", issue_instruction_out, exp_q.pop_front());
            end
            if (error_out) check_eq("fill_error", error_out, 0);
        end
        instr_valid_in = 1'b0;
        instr_in       = 16'h0000;
        check_eq("full_reached", (full_seen != 0), 1);
        check_eq("full_max_count", max_cnt, 16);
        check_eq("fill_all_pushed", idx, stim_q.size());
        check_eq("fill_all_issued", exp_q.size(), 0);

        // Reset mid-burst, right after the 2nd payload word is issued.
        clear_vectors();
        stim_q = '{16'h0006, 16'hE001, 16'hE002, 16'hE003, 16'hE004, 16'hE005};
        exp_nops(6);
        exp_word(16'h0006); exp_word(16'hE001); exp_word(16'hE002);
        run_trace("pre_reset");
        reset_in = 1'b1;
        #1;
        check_eq("mid_rst_issue", issue_instruction_out, 16'h0000);
        check_eq("mid_rst_count", fifo_count_out, 0);
        check_eq("mid_rst_busy", busy_out, 0);
        check_eq("mid_rst_state", state_out, 0);
        check_eq("mid_rst_ready", instr_ready_out, 0);
        tick();
        check_eq("mid_rst_issue_held", issue_instruction_out, 16'h0000);
        #2;
        reset_in = 1'b0;
        tick();
        check_eq("post_rst_ready", instr_ready_out, 1);
        check_eq("post_rst_count", fifo_count_out, 0);

        clear_vectors();
        stim_q = '{16'h000A, 16'hF001, 16'hF002, 16'hF003, 16'hF004, 16'hF005};
        exp_nops(6);
        exp_word(16'h000A);
        exp_word(16'hF001); exp_word(16'hF002); exp_word(16'hF003);
        exp_word(16'hF004); exp_word(16'hF005);
        exp_nops(1);
        run_trace("post_rst_burst");
        check_eq("post_rst_busy", busy_out, 0);

        // ------------------------------------------------------ final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
